// File: rtl/addr_seq.sv
// Address-sequencing FSM for the ABL adder. It steps through operand fetch, low/high
// address formation, page-cross fixup and restore, with a cycle enable (rdy) that stalls everything.
module addr_seq (
  input  logic       clk,
  input  logic       RST,
  input  logic       rdy,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       br_cond,
  input  logic       CO,
  output logic [3:0] op,
  output logic       CI,
  output logic       cond,
  output logic       ld_ahl,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       hi_inc,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPND, S_LO, S_HI, S_FIX, S_STK, S_RESTORE
  } state_t;

  localparam logic [2:0] M_ZP     = 3'b000;
  localparam logic [2:0] M_ZPX    = 3'b001;
  localparam logic [2:0] M_ABS    = 3'b010;
  localparam logic [2:0] M_ABSX   = 3'b011;
  localparam logic [2:0] M_BRANCH = 3'b100;
  localparam logic [2:0] M_STACK  = 3'b101;

  state_t     r_state, w_next;
  logic [2:0] r_mode;
  logic       w_ld_ahl, w_ld_pc, w_inc_pc, w_hi_inc, w_done, w_err;
  logic       w_illegal;

  assign w_illegal = (r_mode[2:1] == 2'b11);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_mode  <= 3'b000;
    end else if (rdy) begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_mode <= mode;
    end
  end

  always_comb begin
    w_next   = r_state;
    op       = 4'b0011;
    CI       = 1'b0;
    cond     = 1'b0;
    w_ld_ahl = 1'b0;
    w_ld_pc  = 1'b0;
    w_inc_pc = 1'b0;
    w_hi_inc = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // mode is still unlatched here, so decode illegality from the input
        if (start) w_next = (mode[2:1] == 2'b11) ? S_RESTORE : S_OPND;
      end
      S_OPND: begin
        CI       = 1'b1;
        w_ld_pc  = 1'b1;
        w_inc_pc = 1'b1;
        w_next   = (r_mode == M_STACK) ? S_STK : S_LO;
      end
      S_LO: begin
        w_ld_ahl = 1'b1;
        case (r_mode)
          M_ZP: begin
            op = 4'b1110; cond = 1'b1; w_next = S_RESTORE;
          end
          M_ZPX: begin
            // zero-page wrap: carry out is dropped
            op = 4'b1101; cond = 1'b1; w_next = S_RESTORE;
          end
          M_ABS, M_ABSX: begin
            CI = 1'b1; w_ld_pc = 1'b1; w_inc_pc = 1'b1; w_next = S_HI;
          end
          M_BRANCH: begin
            if (br_cond) begin
              op = 4'b1111; cond = 1'b1; w_ld_pc = 1'b1;
              if (CO) w_next = S_FIX;
              else begin
                w_done = 1'b1; w_next = S_IDLE;
              end
            end else begin
              CI = 1'b1; w_ld_pc = 1'b1; w_inc_pc = 1'b1;
              w_done = 1'b1; w_next = S_IDLE;
            end
          end
          default: w_next = S_RESTORE;
        endcase
      end
      S_HI: begin
        op     = (r_mode == M_ABSX) ? 4'b1001 : 4'b1010;
        w_next = (r_mode == M_ABSX && CO) ? S_FIX : S_RESTORE;
      end
      S_FIX: begin
        w_hi_inc = 1'b1;
        if (r_mode == M_BRANCH) begin
          w_ld_pc = 1'b1; w_done = 1'b1; w_next = S_IDLE;
        end else begin
          w_next = S_RESTORE;
        end
      end
      S_STK: begin
        op     = 4'b0000;
        w_next = S_RESTORE;
      end
      S_RESTORE: begin
        op     = 4'b0110;
        w_done = 1'b1;
        w_err  = w_illegal;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // a stalled cycle keeps the datapath selects but must not commit anything
  assign ld_ahl = w_ld_ahl & rdy;
  assign ld_pc  = w_ld_pc  & rdy;
  assign inc_pc = w_inc_pc & rdy;
  assign hi_inc = w_hi_inc & rdy;
  assign done   = w_done   & rdy;
  assign err    = w_err    & rdy;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_addr_seq.sv
// Scoreboard bench for addr_seq: each transaction is expanded into its list of per-cycle
// expected outputs, the driver pushes one expectation per cycle and a monitor compares.
module tb_addr_seq;

  logic       clk = 1'b0;
  logic       RST, rdy, start, br_cond, CO;
  logic [2:0] mode;
  logic [3:0] op;
  logic       CI, cond, ld_ahl, ld_pc, inc_pc, hi_inc, busy, done, err;

  addr_seq dut (
    .clk(clk), .RST(RST), .rdy(rdy), .start(start), .mode(mode),
    .br_cond(br_cond), .CO(CO), .op(op), .CI(CI), .cond(cond),
    .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc), .hi_inc(hi_inc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [3:0] op;
    logic       ci, cond, ahl, ldpc, incpc, hinc, done, err;
  } out_t;

  typedef struct {
    out_t o;
    bit   sens;  // outputs at this step depend on br_cond/CO
    int   id;
  } step_t;

  step_t seq[$];   // remaining steps of the running transaction
  step_t sb[$];    // scoreboard: expectation for each driven cycle
  bit    t_br, t_co;
  int    checks = 0, errors = 0, cyc = 0;
  out_t  act;

  assign act = {busy, op, CI, cond, ld_ahl, ld_pc, inc_pc, hi_inc, done, err};

  function automatic out_t mk(bit b, bit [3:0] o, bit ci, bit cd, bit ah, bit lp,
                              bit ip, bit hi, bit dn, bit er);
    out_t r;
    r = {b, o, ci, cd, ah, lp, ip, hi, dn, er};
    return r;
  endfunction

  task automatic add(out_t o, bit s, int id);
    step_t st;
    st.o = o; st.sens = s; st.id = id;
    seq.push_back(st);
  endtask

  // Expected cycle-by-cycle outputs of one transaction, straight from the mode rules.
  task automatic load(bit [2:0] m, bit b, bit c);
    out_t opnd, rest, lo_abs, fix;
    seq.delete();
    t_br = b; t_co = c;
    opnd   = mk(1, 4'b0011, 1, 0, 0, 1, 1, 0, 0, 0);
    rest   = mk(1, 4'b0110, 0, 0, 0, 0, 0, 0, 1, 0);
    lo_abs = mk(1, 4'b0011, 1, 0, 1, 1, 1, 0, 0, 0);
    fix    = mk(1, 4'b0011, 0, 0, 0, 0, 0, 1, 0, 0);
    if (m[2:1] == 2'b11) begin
      add(mk(1, 4'b0110, 0, 0, 0, 0, 0, 0, 1, 1), 0, 70);
      return;
    end
    add(opnd, 0, 10);
    case (m)
      3'd0: begin add(mk(1, 4'b1110, 0, 1, 1, 0, 0, 0, 0, 0), 0, 20); add(rest, 0, 70); end
      3'd1: begin add(mk(1, 4'b1101, 0, 1, 1, 0, 0, 0, 0, 0), 0, 21); add(rest, 0, 70); end
      3'd2: begin
        add(lo_abs, 0, 22); add(mk(1, 4'b1010, 0, 0, 0, 0, 0, 0, 0, 0), 0, 30); add(rest, 0, 70);
      end
      3'd3: begin
        add(lo_abs, 0, 22); add(mk(1, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 0), 1, 31);
        if (c) add(fix, 0, 40);
        add(rest, 0, 70);
      end
      3'd4: begin
        if (!b) add(mk(1, 4'b0011, 1, 0, 1, 1, 1, 0, 1, 0), 1, 24);
        else begin
          add(mk(1, 4'b1111, 0, 1, 1, 1, 0, 0, !c, 0), 1, 25);
          if (c) add(mk(1, 4'b0011, 0, 0, 0, 1, 0, 1, 1, 0), 0, 41);
        end
      end
      default: begin add(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0), 0, 50); add(rest, 0, 70); end
    endcase
  endtask

  // One clock: drive inputs, push the expectation, advance the model at the edge.
  task automatic cycle(bit r, bit s, bit [2:0] m, bit b, bit c, bit rst);
    step_t e;
    RST = rst; rdy = r; start = s; mode = m; br_cond = b; CO = c;
    if (seq.size() == 0) begin
      e.o = mk(0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0); e.sens = 0; e.id = 0;
    end else begin
      e = seq[0];
      if (e.sens) begin br_cond = t_br; CO = t_co; end
    end
    if (!r) begin
      e.o.ahl = 0; e.o.ldpc = 0; e.o.incpc = 0; e.o.hinc = 0; e.o.done = 0; e.o.err = 0;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    cyc++;
    if (rst) seq.delete();
    else if (r) begin
      if (seq.size() == 0) begin
        if (s) load(m, b, c);
      end else void'(seq.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      step_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL cyc%0d step%0d {busy,op,CI,cond,ahl,ldpc,incpc,hinc,done,err}: got %b want %b",
                 cyc, e.id, act, e.o);
      end
    end
  end

  initial begin
    RST = 1; rdy = 0; start = 0; mode = 0; br_cond = 0; CO = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // ABS, with start pulses during busy that must be ignored
    cycle(1, 1, 2, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0); cycle(1, 1, 5, 0, 0, 0); cycle(1, 0, 0, 0, 1, 0); cycle(1, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // ABSX with page cross
    cycle(1, 1, 3, 0, 1, 0);
    repeat (5) cycle(1, 0, 0, 0, 0, 0);
    // BRANCH not taken, then taken with page cross, then taken without
    cycle(1, 1, 4, 0, 0, 0); repeat (2) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 1, 1, 0); repeat (3) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 1, 0, 0); repeat (2) cycle(1, 0, 0, 0, 0, 0);
    // ZPX with a 3-cycle stall in LO
    cycle(1, 1, 1, 0, 1, 0); cycle(1, 0, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    repeat (3) cycle(1, 0, 0, 0, 1, 0);
    // illegal mode, start during its RESTORE cycle
    cycle(1, 1, 6, 0, 0, 0); cycle(1, 1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 7, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0);
    // STACK
    cycle(1, 1, 5, 0, 0, 0); repeat (4) cycle(1, 0, 0, 0, 0, 0);
    // reset in HI of ABS, then ZP
    cycle(1, 1, 2, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0); repeat (4) cycle(1, 0, 0, 0, 0, 0);
    // randomized traffic
    repeat (4000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
    end
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_seq.md
ADDR_SEQ -- requirements
Module: addr_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port rdy, input, 1 bit: cycle enable; 0 stalls the sequencer.
REQ-004 The block SHALL have port start, input, 1 bit: request a new address sequence; sampled only in IDLE with rdy=1.
REQ-005 The block SHALL have port mode, input, 3 bits: 000 ZP, 001 ZPX, 010 ABS, 011 ABSX, 100 BRANCH, 101 STACK, 11x illegal; latched when start is accepted.
REQ-006 The block SHALL have port br_cond, input, 1 bit: branch-taken flag, sampled in state LO of BRANCH.
REQ-007 The block SHALL have port CO, input, 1 bit: carry out of the ABL adder.
REQ-008 The block SHALL have port op, output, 4 bits: ABL operation select. op[3:2] selects the base: 00 zero, 01 PCL, 10 AHL, 11 DB when cond=1. op[1:0] selects the sum: 00 REG, 01 base+REG, 10 base, 11 base+ABL.
REQ-009 The block SHALL have port CI, output, 1 bit: ABL adder carry in.
REQ-010 The block SHALL have port cond, output, 1 bit: enables the DB base.
REQ-011 The block SHALL have ports ld_ahl, ld_pc and inc_pc, outputs, 1 bit each: ABL register load strobes.
REQ-012 The block SHALL have port hi_inc, output, 1 bit: request to increment ABH by one (page-cross fixup).
REQ-013 The block SHALL have ports busy, done and err, outputs, 1 bit each: busy = state≠IDLE; done = final-cycle pulse; err = illegal-mode pulse.

Function
REQ-014 The block SHALL have states IDLE, OPND, LO, HI, FIX, STK and RESTORE, one-hot or binary, with one state per enabled cycle.
REQ-015 The IDLE outputs SHALL be op=0011, CI=0 and cond=0, with all strobes 0. start with rdy=1 latches mode and moves to OPND, except illegal modes, which go to RESTORE.
REQ-016 The OPND outputs SHALL be op=0011, CI=1, ld_pc=1 and inc_pc=1. Next state is STK for STACK, else LO.
REQ-017 In LO, ld_ahl SHALL be 1, with per-mode behaviour:
- ZP: op=1110, cond=1, CI=0; next state RESTORE.
- ZPX: op=1101, cond=1, CI=0; next state RESTORE; CO ignored (zero-page wrap, hi_inc=0).
- ABS/ABSX: op=0011, CI=1, ld_pc=1, inc_pc=1; next state HI.
- BRANCH, br_cond=1: op=1111, cond=1, CI=0, ld_pc=1; next state FIX if CO=1, else IDLE with done=1.
- BRANCH, br_cond=0: op=0011, CI=1, ld_pc=1, inc_pc=1; done=1; next state IDLE.
REQ-018 In HI, ABS SHALL drive op=1010 and ABSX SHALL drive op=1001, with CI=0. Next state is FIX if ABSX and CO=1, else RESTORE.
REQ-019 The FIX outputs SHALL be op=0011, CI=0 and hi_inc=1. For BRANCH, ld_pc=1 and done=1, with next state IDLE. Otherwise next state is RESTORE.
REQ-020 The STK outputs SHALL be op=0000 and CI=0; next state RESTORE.
REQ-021 The RESTORE outputs SHALL be op=0110 and CI=0, with done=1 and err=1 iff the latched mode is illegal; next state IDLE.
REQ-022 With rdy=0, the state and latched mode SHALL hold, op/CI/cond SHALL keep their current-state values, and ld_ahl, ld_pc, inc_pc, hi_inc, done and err SHALL be forced to 0.
REQ-023 start while busy SHALL be ignored (no queueing), and a start coincident with done SHALL be ignored.
REQ-024 Latency from start accepted to done SHALL be: ZP/ZPX 3, ABS 4, ABSX 4 (5 on page cross), BRANCH 2 (3 on page cross), STACK 3, illegal 1 (cycles with rdy=1).
REQ-025 CO SHALL be evaluated only in the HI state (ABSX) and the LO state (BRANCH taken); elsewhere it has no effect.

Reset
REQ-026 With RST=1 at a clock edge, the block SHALL enter IDLE, clear the latched mode to 000, and drive busy=done=err=0 and all strobes 0 the next cycle, regardless of rdy or the current state (including mid-sequence).
REQ-027 RST SHALL take priority over start and rdy.

Verification
REQ-028 The bench SHALL check ABS with rdy=1: start with mode=010 → states OPND, LO, HI, RESTORE; op sequence 0011, 0011, 1010, 0110; done in cycle 4; hi_inc never set.
REQ-029 The bench SHALL check ABSX with page cross: mode=011, CO=1 in HI → FIX inserted with hi_inc=1; done in cycle 5.
REQ-030 The bench SHALL check BRANCH: br_cond=0 → done in cycle 2 with op=0011 and CI=1; br_cond=1 with CO=1 → FIX with ld_pc=1 and hi_inc=1, done in cycle 3.
REQ-031 The bench SHALL check a stall: rdy=0 for 3 cycles in LO of ZPX → state held, ld_ahl=0 throughout, op=1101 held; done 3 enabled cycles after start.
REQ-032 The bench SHALL check illegal mode and busy start: mode=110 → RESTORE, then done=1 and err=1 one cycle after start; a start pulse during busy has no effect.
REQ-033 The bench SHALL check reset mid-operation: RST in HI of ABS → IDLE next cycle with busy=0; a following ZP start completes normally in 3 cycles.
